// File: rtl/nios_cpu_div_cell_if.sv
// Request/response bundle between the M-stage and the iterative divide cell.
// The master drives operands and control; the slave returns status and results.
interface nios_cpu_div_cell_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] M_div_src1;
    logic [WIDTH-1:0] M_div_src2;
    logic             M_div_signed;
    logic             M_div_start;
    logic             M_div_abort;
    logic             M_div_busy;
    logic             M_div_done;
    logic [WIDTH-1:0] M_div_quotient;
    logic [WIDTH-1:0] M_div_remainder;

    modport master (
        output M_div_src1, M_div_src2, M_div_signed, M_div_start, M_div_abort,
        input  M_div_busy, M_div_done, M_div_quotient, M_div_remainder
    );

    modport slave (
        input  M_div_src1, M_div_src2, M_div_signed, M_div_start, M_div_abort,
        output M_div_busy, M_div_done, M_div_quotient, M_div_remainder
    );
endinterface

// File: rtl/nios_cpu_div_cell.sv
// Radix-2 restoring divider for DIV/DIVU: magnitudes are divided one bit per
// cycle, then signs are applied in a final fix-up cycle (C truncation semantics).
module nios_cpu_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    nios_cpu_div_cell_if.slave div
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

    state_t           state, state_nxt;
    logic             accept, step, fire;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem, quo, dvs, src1_raw;
    logic             neg_q, neg_r, dz;
    logic             busy, done;
    logic [WIDTH-1:0] quotient, remainder;

    logic [WIDTH-1:0] mag1, mag2;
    logic             sign1, sign2;
    logic [WIDTH:0]   partial, diff;

    assign sign1 = div.M_div_signed & div.M_div_src1[WIDTH-1];
    assign sign2 = div.M_div_signed & div.M_div_src2[WIDTH-1];
    // The most negative value negates to itself, which is its correct unsigned magnitude.
    assign mag1  = sign1 ? -div.M_div_src1 : div.M_div_src1;
    assign mag2  = sign2 ? -div.M_div_src2 : div.M_div_src2;

    // Remainder is always below the divisor, so the shifted partial fits WIDTH+1 bits.
    assign partial = {rem, quo[WIDTH-1]};
    assign diff    = partial - {1'b0, dvs};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        fire      = 1'b0;
        unique case (state)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped, not queued.
                if (div.M_div_start && !div.M_div_abort && !done) begin
                    accept    = 1'b1;
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (div.M_div_abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == LAST) state_nxt = S_FIX;
                end
            end
            S_FIX: begin
                state_nxt = S_IDLE;
                fire      = !div.M_div_abort;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            src1_raw  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            busy <= (state_nxt != S_IDLE);
            done <= fire;
            if (accept) begin
                cnt      <= '0;
                rem      <= '0;
                quo      <= mag1;
                dvs      <= mag2;
                src1_raw <= div.M_div_src1;
                neg_q    <= sign1 ^ sign2;
                neg_r    <= sign1;
                dz       <= (div.M_div_src2 == '0);
            end else if (step) begin
                cnt <= cnt + CW'(1);
                rem <= diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            end
            if (fire) begin
                quotient  <= dz ? '1       : (neg_q ? -quo : quo);
                remainder <= dz ? src1_raw : (neg_r ? -rem : rem);
            end
        end
    end

    assign div.M_div_busy      = busy;
    assign div.M_div_done      = done;
    assign div.M_div_quotient  = quotient;
    assign div.M_div_remainder = remainder;
endmodule
